// File: rtl/psram_burst_ctrl.sv
// Fixed-latency burst master for an MT45W8-class pseudo-SRAM.
// One request in flight at a time; every strobe and handshake output is registered.
module psram_burst_ctrl #(
    parameter int D_WIDTH   = 16,
    parameter int A_WIDTH   = 16,
    parameter int LATENCY   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] wr_data,
    output logic               wr_next,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               rd_valid,
    output logic               done,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic               adv_L,
    output logic               ce_L,
    output logic               oe_L,
    output logic               we_L,
    output logic               ub_L,
    output logic               lb_L,
    output logic               mcre,
    input  logic               mem_wait,
    inout  wire  [D_WIDTH-1:0] mem_data
);
    localparam int WC_W = (LATENCY - 1 > 1) ? $clog2(LATENCY - 1) : 1;
    localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(LATENCY - 2);
    localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADV, S_WAIT, S_DATA, S_RECOVER} state_e;

    state_e             state_q;
    logic [WC_W-1:0]    wait_cnt_q;
    logic [BC_W-1:0]    beat_cnt_q;
    logic               we_q;
    logic [A_WIDTH-1:0] addr_q;
    logic [D_WIDTH-1:0] rd_data_q;
    logic               ready_q, rd_valid_q, wr_next_q, done_q, drive_q;
    logic               ce_l_q, adv_l_q, oe_l_q, we_l_q, bs_l_q;

    // WAIT is only meaningful in variable-latency mode.
    logic unused_wait;
    assign unused_wait = mem_wait;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            beat_cnt_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            rd_data_q  <= '0;
            ready_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            wr_next_q  <= 1'b0;
            done_q     <= 1'b0;
            drive_q    <= 1'b0;
            ce_l_q     <= 1'b1;
            adv_l_q    <= 1'b1;
            oe_l_q     <= 1'b1;
            we_l_q     <= 1'b1;
            bs_l_q     <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        state_q <= S_ADV;
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        ready_q <= 1'b0;
                        ce_l_q  <= 1'b0;
                        adv_l_q <= 1'b0;
                        we_l_q  <= ~req_we;
                        bs_l_q  <= 1'b0;
                    end
                end
                S_ADV: begin
                    state_q    <= S_WAIT;
                    wait_cnt_q <= '0;
                    adv_l_q    <= 1'b1;
                    we_l_q     <= 1'b1;
                    oe_l_q     <= we_q;
                end
                S_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q    <= S_DATA;
                        beat_cnt_q <= '0;
                        wr_next_q  <= we_q;
                        drive_q    <= we_q;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WC_W'(1);
                    end
                end
                S_DATA: begin
                    if (!we_q) begin
                        rd_data_q  <= mem_data;
                        rd_valid_q <= 1'b1;
                    end
                    if (beat_cnt_q == BEAT_LAST) begin
                        state_q   <= S_RECOVER;
                        wr_next_q <= 1'b0;
                        drive_q   <= 1'b0;
                        ce_l_q    <= 1'b1;
                        oe_l_q    <= 1'b1;
                        bs_l_q    <= 1'b1;
                        done_q    <= 1'b1;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + BC_W'(1);
                    end
                end
                S_RECOVER: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Write data passes straight through; the host holds each word until wr_next.
    assign mem_data  = drive_q ? wr_data : {D_WIDTH{1'bz}};

    assign req_ready = ready_q;
    assign wr_next   = wr_next_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign mem_addr  = addr_q;
    assign adv_L     = adv_l_q;
    assign ce_L      = ce_l_q;
    assign oe_L      = oe_l_q;
    assign we_L      = we_l_q;
    assign ub_L      = bs_l_q;
    assign lb_L      = bs_l_q;
    assign mcre      = 1'b0;

endmodule

// File: tb/tb_psram_burst_ctrl.sv
// Bench for psram_burst_ctrl: pin-level burst PSRAM model plus a host-level shadow
// memory that predicts every read word and the cycle timing of each burst.
module tb_psram_burst_ctrl;
    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int LAT = 4;
    localparam int BL  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          mem_wait = 1'b0;
    logic          req_ready, wr_next, rd_valid, done;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] mem_addr;
    logic          adv_L, ce_L, oe_L, we_L, ub_L, lb_L, mcre;
    wire  [DW-1:0] mem_data;

    logic          dev_oe = 1'b0;
    logic [DW-1:0] dev_dq = '0;
    assign mem_data = dev_oe ? dev_dq : {DW{1'bz}};

    psram_burst_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .LATENCY(LAT), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .wr_data(wr_data), .wr_next(wr_next),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .mem_addr(mem_addr),
        .adv_L(adv_L), .ce_L(ce_L), .oe_L(oe_L), .we_L(we_L), .ub_L(ub_L), .lb_L(lb_L),
        .mcre(mcre), .mem_wait(mem_wait), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] dmem   [0:65535];
    logic [DW-1:0] shadow [0:65535];
    logic [DW-1:0] wbuf   [BL];
    int n_cmp = 0;
    int n_bad = 0;
    int txn_no = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Device: latches address on ADV, data beats start LAT cycles later.
    logic          dev_act = 1'b0;
    logic          dev_wr = 1'b0;
    logic [AW-1:0] dev_base = '0;
    int            dev_c = 0;
    always @(negedge clk) begin
        logic [AW-1:0] a;
        if (ce_L) begin
            dev_act = 1'b0;
            dev_oe  = 1'b0;
        end else begin
            if (!adv_L) begin
                dev_act  = 1'b1;
                dev_base = mem_addr;
                dev_wr   = !we_L;
                dev_c    = 0;
            end else if (dev_act) begin
                dev_c++;
            end
            dev_oe = 1'b0;
            if (dev_act && dev_c >= LAT && dev_c < LAT + BL) begin
                a = dev_base + AW'(dev_c - LAT);
                if (dev_wr) dmem[a] = mem_data;
                else if (!oe_L) begin
                    dev_dq = dmem[a];
                    dev_oe = 1'b1;
                end
            end
        end
    end

    task automatic run_txn(input bit we, input logic [AW-1:0] addr);
        logic [DW-1:0] expq[$];
        logic [AW-1:0] addr_adv;
        int  n_adv, adv_at, n_rd, first_rd, n_wrn, first_wrn, last_wrn, n_done, done_at;
        int  oe_lo, ce_lo, bs_lo, widx;
        bit  got, pend, weadv, ce_rec;
        n_adv = 0; adv_at = 0; n_rd = 0; first_rd = 0; n_wrn = 0; first_wrn = 0;
        last_wrn = 0; n_done = 0; done_at = 0; oe_lo = 0; ce_lo = 0; bs_lo = 0;
        weadv = 1'b0; ce_rec = 1'b0; addr_adv = '0;
        for (int k = 0; k < BL; k++) expq.push_back(shadow[addr + AW'(k)]);
        txn_no++;
        $display("txn %0d: %s addr=0x%04h", txn_no, we ? "WR" : "RD", addr);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; widx = 0; wr_data = wbuf[0];
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            got = req_ready;
        end
        chk("accept", 32'(got), 32'(1));
        if (!got) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = AW'($urandom); req_we = 1'($urandom);
        pend = 1'b0;
        for (int c = 1; c <= LAT + BL + 2; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
                if (pend) begin
                    widx++;
                    wr_data = (widx < BL) ? wbuf[widx] : DW'($urandom);
                    pend = 1'b0;
                end
            end
            @(negedge clk);
            if (!adv_L) begin n_adv++; adv_at = c; weadv = !we_L; addr_adv = mem_addr; end
            if (!ce_L) ce_lo++;
            if (!oe_L) oe_lo++;
            if (!ub_L && !lb_L) bs_lo++;
            if (wr_next) begin
                if (n_wrn == 0) first_wrn = c;
                last_wrn = c; n_wrn++; pend = 1'b1;
            end
            if (rd_valid) begin
                if (n_rd == 0) first_rd = c;
                if (n_rd < BL) chk("rd_data", 32'(rd_data), 32'(expq[n_rd]));
                n_rd++;
            end
            if (done) begin n_done++; done_at = c; end
            if (c == LAT + BL + 1) ce_rec = ce_L;
        end
        chk("adv_count", 32'(n_adv), 32'(1));
        chk("adv_cycle", 32'(adv_at), 32'(1));
        chk("we_in_adv", 32'(weadv), 32'(we));
        chk("mem_addr", 32'(addr_adv), 32'(addr));
        chk("ce_low_cycles", 32'(ce_lo), 32'(LAT + BL));
        chk("ublb_low_cycles", 32'(bs_lo), 32'(LAT + BL));
        chk("oe_low_cycles", 32'(oe_lo), we ? 32'(0) : 32'(LAT - 1 + BL));
        chk("done_count", 32'(n_done), 32'(1));
        chk("done_cycle", 32'(done_at), 32'(LAT + BL + 1));
        chk("ce_in_recover", 32'(ce_rec), 32'(1));
        chk("ready_back", 32'(req_ready), 32'(1));
        if (we) begin
            chk("wr_next_count", 32'(n_wrn), 32'(BL));
            chk("wr_next_first", 32'(first_wrn), 32'(LAT + 1));
            chk("wr_next_last", 32'(last_wrn), 32'(LAT + BL));
            chk("rd_valid_on_wr", 32'(n_rd), 32'(0));
            for (int k = 0; k < BL; k++) shadow[addr + AW'(k)] = wbuf[k];
        end else begin
            chk("rd_count", 32'(n_rd), 32'(BL));
            chk("rd_first_cycle", 32'(first_rd), 32'(LAT + 2));
            chk("wr_next_on_rd", 32'(n_wrn), 32'(0));
        end
    endtask

    task automatic run_b2b(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        logic [DW-1:0] expq[$];
        int n_adv, adv0, adv1, n_rd, n_done;
        n_adv = 0; adv0 = 0; adv1 = 0; n_rd = 0; n_done = 0;
        for (int k = 0; k < BL; k++) expq.push_back(shadow[a0 + AW'(k)]);
        for (int k = 0; k < BL; k++) expq.push_back(shadow[a1 + AW'(k)]);
        txn_no++;
        $display("txn %0d: RD,RD back-to-back addr=0x%04h,0x%04h", txn_no, a0, a1);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!adv_L) begin
                n_adv++;
                if (n_adv == 1) begin adv0 = c; req_addr = a1; end
                if (n_adv == 2) begin adv1 = c; req_valid = 1'b0; end
            end
            if (rd_valid) begin
                if (n_rd < 2 * BL) chk("b2b_rd_data", 32'(rd_data), 32'(expq[n_rd]));
                n_rd++;
            end
            if (done) n_done++;
        end
        req_valid = 1'b0;
        chk("b2b_adv_count", 32'(n_adv), 32'(2));
        chk("b2b_adv_spacing", 32'(adv1 - adv0), 32'(LAT + BL + 2));
        chk("b2b_rd_count", 32'(n_rd), 32'(2 * BL));
        chk("b2b_done_count", 32'(n_done), 32'(2));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, widx, nd;
        bit pend;
        for (int i = 0; i < 65536; i++) begin dmem[i] = '0; shadow[i] = '0; end

        // Reset held with a pending request.
        rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_strobes", 32'({ce_L, adv_L, oe_L, we_L, ub_L, lb_L}), 32'(6'h3F));
            chk("rst_outs", 32'({mcre, rd_valid, wr_next, done}), 32'(0));
            chk("rst_addr", 32'(mem_addr), 32'(0));
            chk("rst_rd_data", 32'(rd_data), 32'(0));
        end
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'(1));
        chk("no_adv_after_rst", 32'(adv_L), 32'(1));

        // Write then read at 0x0010.
        for (int k = 0; k < BL; k++) wbuf[k] = DW'(16'hA001 + k);
        run_txn(1'b1, 16'h0010);
        run_txn(1'b0, 16'h0010);

        // Wrap across the top of the address space.
        for (int k = 0; k < BL; k++) wbuf[k] = DW'(16'h1111 * (k + 1));
        run_txn(1'b1, 16'hFFFE);
        run_txn(1'b0, 16'hFFFE);
        run_txn(1'b0, 16'h0000);

        run_b2b(16'h0010, 16'hFFFE);

        // Reset in the second write DATA cycle.
        for (int k = 0; k < BL; k++) wbuf[k] = DW'($urandom);
        txn_no++;
        $display("txn %0d: WR addr=0x0100 aborted by reset", txn_no);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0100; wr_data = wbuf[0];
        seen = 0; widx = 0; nd = 0; pend = 1'b0;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (pend) begin widx++; wr_data = wbuf[widx]; pend = 1'b0; end
            end
            @(negedge clk);
            if (!adv_L) req_valid = 1'b0;
            if (done) nd++;
            if (wr_next) begin seen++; pend = 1'b1; end
        end
        req_valid = 1'b0;
        chk("mid_reached_beat2", 32'(seen), 32'(2));
        rst = 1'b0;
        #1;
        chk("mid_rst_ce", 32'(ce_L), 32'(1));
        chk("mid_rst_strobes", 32'({adv_L, oe_L, we_L, ub_L, lb_L}), 32'(5'h1F));
        chk("mid_rst_wr_next", 32'(wr_next), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_ready", 32'(req_ready), 32'(1));
        chk("mid_no_done", 32'(nd + int'(done)), 32'(0));
        for (int k = 0; k < BL; k++) wbuf[k] = DW'($urandom);
        run_txn(1'b1, 16'h0100);
        run_txn(1'b0, 16'h0100);

        // Randomized mix, addresses clustered so reads hit earlier writes and the wrap.
        for (int i = 0; i < 14; i++) begin
            bit            we;
            logic [AW-1:0] a;
            we = 1'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFC + $urandom_range(0, 3))
                                              : AW'($urandom_range(0, 40));
            for (int k = 0; k < BL; k++) wbuf[k] = DW'($urandom);
            run_txn(we, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/psram_burst_ctrl.md
# psram_burst_ctrl

Synchronous burst master for the Micron MT45W8 pseudo-SRAM running in fixed-latency burst read/write mode. It accepts single-request, fixed-length burst transactions from an on-chip host port and drives the device control strobes, address, and bidirectional data bus with exact cycle timing. It sits between the system bus adapter and the external pseudo-SRAM pins, or the team's pseudo-SRAM burst model in simulation.

## Interface
- D_WIDTH, 16: data bus width.
- A_WIDTH, 16: address width.
- LATENCY, 4: cycles from the ADV cycle to the first data cycle; must be ≥ 2.
- BURST_LEN, 4: words per burst; must be ≥ 1.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  host request strobe.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
- req_we  in  1  1 = write burst, 0 = read burst; sampled at acceptance.
- req_addr  in  A_WIDTH  start word address; sampled at acceptance.
- wr_data  in  D_WIDTH  current write word; the host holds it until wr_next.
- wr_next  out  1  high in each write DATA cycle; wr_data is consumed at that cycle's closing edge.
- rd_data  out  D_WIDTH  registered read word.
- rd_valid  out  1  one-cycle pulse per read word.
- done  out  1  one-cycle pulse in the RECOVER cycle.
- mem_addr  out  A_WIDTH  registered address; holds the accepted start address for the whole transaction.
- adv_L, ce_L, oe_L, we_L, ub_L, lb_L  out  1  device strobes, active-low.
- mcre  out  1  constant 0; no register configuration.
- mem_wait  in  1  device WAIT; ignored in fixed-latency mode.
- mem_data  inout  D_WIDTH  device data bus.

## Operation
- FSM states:
  - IDLE → ADV on request acceptance.
  - ADV → WAIT after 1 cycle.
  - WAIT → DATA after LATENCY−1 cycles.
  - DATA → RECOVER after BURST_LEN cycles.
  - RECOVER → IDLE after 1 cycle.
- wait_cnt counts 0..LATENCY−2 in WAIT. beat_cnt counts 0..BURST_LEN−1 in DATA. Each counter is $clog2 of its limit wide (minimum 1 bit) and clears on entry to its state.
- ce_L: 0 in ADV, WAIT, and DATA; 1 in IDLE and RECOVER.
- adv_L: 0 only in ADV.
- we_L: 0 only in ADV of a write burst.
- ub_L and lb_L: 0 in ADV, WAIT, and DATA; 1 otherwise.
- oe_L: 0 in WAIT and DATA of a read burst; 1 otherwise.
- mem_data:
  - Driven with wr_data only in write DATA cycles.
  - High-Z in every other state and during reset.
  - Never driven while oe_L = 0.
- Reads: mem_data is sampled at each DATA cycle's closing edge into rd_data, with rd_valid = 1 in the following cycle. Words appear in burst order, so the last rd_valid coincides with the RECOVER cycle.
- Writes: wr_next = 1 in every write DATA cycle. The host advances wr_data after each wr_next and must present word 0 before the first DATA cycle.
- Device address increments and wraps inside the device. The controller never increments mem_addr.
- A request arriving while busy waits, since req_ready = 0. req_valid held high through RECOVER is accepted in the next IDLE cycle.

## Timing
- Cycle n = ADV. WAIT occupies n+1..n+LATENCY−1. DATA occupies n+LATENCY..n+LATENCY+BURST_LEN−1. RECOVER = n+LATENCY+BURST_LEN.
- Minimum ADV-to-ADV spacing is LATENCY+BURST_LEN+2 cycles (10 with defaults): RECOVER, then an IDLE accept cycle.
- Read latency from acceptance edge to first rd_valid: LATENCY+1 cycles.
- Reset values:
  - State IDLE.
  - ce_L, adv_L, oe_L, we_L, ub_L, lb_L = 1.
  - mcre = 0, mem_addr = 0, rd_data = 0.
  - rd_valid, wr_next, done = 0.
  - req_ready = 1 after reset release.
  - mem_data high-Z.
- Reset mid-transaction:
  - The controller aborts immediately and asynchronously forces the reset values.
  - The partial burst is discarded and no done pulse is issued.
  - ce_L = 1 returns the device to idle, so the next request after release completes normally.

## Test plan
- Reset: hold rst = 0 for 3 cycles with req_valid = 1 → all strobes = 1, mem_data = Z, no acceptance; req_ready = 1 on the first cycle after release.
- Write then read: write at 0x0010 with words 0xA001..0xA004, then read at 0x0010 → four rd_valid pulses carrying 0xA001, 0xA002, 0xA003, 0xA004 in order; the first pulse occurs 5 cycles after the acceptance edge.
- Strobe timing: for one write, adv_L = 0 for exactly 1 cycle with we_L = 0 in that same cycle; wr_next is high for 4 cycles starting 4 cycles after ADV; ce_L = 1 in the cycle after the last wr_next; done pulses once.
- Back-to-back: hold req_valid = 1 for two read requests → the two ADV cycles are exactly 10 cycles apart, with no overlapping rd_valid and a single done per burst.
- Wrap: write at 0xFFFE with 0x1111..0x4444, then read at 0xFFFE and at 0x0000 → words at addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 hold 0x1111, 0x2222, 0x3333, 0x4444.
- Mid-burst reset: assert rst in the 2nd write DATA cycle → ce_L = 1 and mem_data = Z in the same cycle; after release, a full write/read at 0x0100 returns the correct data.
